// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and framer state encodings.
package uart_tx_mmio_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int unsigned STAT_EMPTY    = 0;
    localparam int unsigned STAT_FULL     = 1;
    localparam int unsigned STAT_BUSY     = 2;
    localparam int unsigned STAT_OVERFLOW = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push while full is accepted only
// when a pop retires the head in the same cycle.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO and serial framer.
// Define UART_TX_PARITY_EN to add an optional even-parity bit (CTRL bit1).
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 434,
    parameter int unsigned DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    logic [DIV_W-1:0]  baud_div_q;
    logic              tx_en_q;
    logic              overflow_q;
`ifdef UART_TX_PARITY_EN
    logic              parity_en_q;
    logic              par_q;
    logic              par_n;
`endif

    state_e            state_q;
    state_e            state_n;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  cnt_n;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_n;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_n;
    logic              tx_q;
    logic              tx_n;

    logic              wr_txdata;
    logic              wr_status;
    logic              wr_baud;
    logic              wr_ctrl;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;
    logic [DIV_W-1:0]  p_m1;
    logic              bit_end;
    logic              unused_bits;

    assign wr_txdata   = sel && mem_write && (addr[3:2] == OFF_TXDATA);
    assign wr_status   = sel && mem_write && (addr[3:2] == OFF_STATUS);
    assign wr_baud     = sel && mem_write && (addr[3:2] == OFF_BAUD);
    assign wr_ctrl     = sel && mem_write && (addr[3:2] == OFF_CTRL);
    assign pop         = (state_q == ST_IDLE) && tx_en_q && !fifo_empty;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:DATA_W]};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_txdata),
        .pop   (pop),
        .wdata (wdata[DATA_W-1:0]),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A divider of 0 behaves as 1; comparing with >= lets a shrinking divider end the bit at once.
    assign p_m1    = (baud_div_q == '0) ? '0 : baud_div_q - DIV_W'(1);
    assign bit_end = (cnt_q >= p_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div_q  <= DIV_W'(DEFAULT_DIV);
            tx_en_q     <= 1'b1;
            overflow_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en_q <= 1'b0;
`endif
        end else begin
            if (wr_baud) baud_div_q <= wdata[DIV_W-1:0];
            if (wr_ctrl) begin
                tx_en_q     <= wdata[0];
`ifdef UART_TX_PARITY_EN
                parity_en_q <= wdata[1];
`endif
            end
            if (wr_txdata && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end else if (wr_status && wdata[STAT_OVERFLOW]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            shift_q <= shift_n;
            tx_q    <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    // Framer next state; the line level is computed from the next state so uart_tx is a flop.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        shift_n = shift_q;
        tx_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                if (pop) begin
                    shift_n = head;
                    idx_n   = '0;
                    state_n = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^head;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_DATA;
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_n = parity_en_q ? ST_PARITY : ST_STOP;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        idx_n   = idx_q + IDX_W'(1);
                        shift_n = shift_q >> 1;
                    end
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_STOP;
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase

        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_n = par_n;
`endif
            default:   tx_n = 1'b1;
        endcase
    end

    assign uart_tx = tx_q;

    // Load data is combinational so the core sees it in the same cycle as mem_read.
    always_comb begin
        rdata = '0;
        if (sel && mem_read) begin
            case (addr[3:2])
                OFF_STATUS: begin
                    rdata[STAT_EMPTY]    = fifo_empty;
                    rdata[STAT_FULL]     = fifo_full;
                    rdata[STAT_BUSY]     = (state_q != ST_IDLE);
                    rdata[STAT_OVERFLOW] = overflow_q;
                end
                OFF_BAUD: rdata = 32'(baud_div_q);
                OFF_CTRL: begin
                    rdata[0] = tx_en_q;
`ifdef UART_TX_PARITY_EN
                    rdata[1] = parity_en_q;
`endif
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected frames, a line
// monitor decodes uart_tx cycle by cycle and compares against them.
module tb_uart_tx_mmio;

    localparam int unsigned DEF_DIV = 434;
    localparam logic [31:0] BASE    = 32'h4000_0000;
    localparam logic [31:0] A_TX    = BASE + 32'h0;
    localparam logic [31:0] A_ST    = BASE + 32'h4;
    localparam logic [31:0] A_BAUD  = BASE + 32'h8;
    localparam logic [31:0] A_CTRL  = BASE + 32'hC;

    typedef struct {
        logic [7:0] data;
        int         p;
        bit         par;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        uart_tx;

    frame_t sb[$];
    int     starts[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     last_wr = 0;
    bit     mon_busy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_mmio #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (DEF_DIV),
        .DIV_W       (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .uart_tx   (uart_tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; mem_write = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        last_wr = cyc;
        sel = 1'b0; mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; mem_read = 1'b1; addr = a;
        #1;
        d = rdata;
        sel = 1'b0; mem_read = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int p, input bit par);
        frame_t f;
        f.data = b; f.p = p; f.par = par;
        sb.push_back(f);
        bus_write(A_TX, 32'(b));
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL drain_timeout: %0d frames still pending after %0d cycles, expected 0", sb.size(), budget);
        end
        repeat (3) @(posedge clk);
    endtask

    // Line monitor: one frame is start + 8 data LSB-first [+ parity] + stop, each held P cycles.
    initial begin : monitor
        frame_t     e;
        logic [10:0] bits;
        int         nb;
        int         bad_b;
        int         bad_s;
        bit         ok;
        bit         abort;
        logic       got;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_start: line low at cycle %0d, expected idle high", cyc);
                    for (int g = 0; g < 5000 && uart_tx === 1'b0; g++) @(negedge clk);
                end else begin
                    e = sb.pop_front();
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
                    nb = 10;
                    if (e.par) begin
                        bits[9] = ^e.data;
                        nb = 11;
                    end
                    ok = 1'b1; abort = 1'b0; bad_b = 0; bad_s = 0; got = 1'b0;
                    for (int b = 0; b < nb && !abort; b++) begin
                        for (int s = 0; s < e.p && !abort; s++) begin
                            if (b != 0 || s != 0) @(negedge clk);
                            if (rst_n !== 1'b1) abort = 1'b1;
                            else if (uart_tx !== bits[b] && ok) begin
                                ok = 1'b0; bad_b = b; bad_s = s; got = uart_tx;
                            end
                        end
                    end
                    if (!abort) begin
                        total++;
                        if (!ok) begin
                            bad++;
                            $display("FAIL frame_%02h: bit %0d sample %0d got %b expected %b",
                                     e.data, bad_b, bad_s, got, bits[bad_b]);
                        end
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] r;
        logic [7:0]  b;
        int          e;
        int          s0;
        int          div;
        int          p;
        int          n;

        rst_n = 1'b0; sel = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state and read gating
        check("reset_line", 32'(uart_tx), 32'h1);
        @(negedge clk);
        sel = 1'b0; mem_read = 1'b1; addr = A_ST;
        #1;
        check("rdata_unselected", rdata, 32'h0);
        sel = 1'b1; mem_read = 1'b0;
        #1;
        check("rdata_no_read", rdata, 32'h0);
        sel = 1'b0;
        bus_read(A_ST, r);   check("reset_status", r, 32'h01);
        bus_read(A_BAUD, r); check("reset_baud", r, 32'(DEF_DIV));
        bus_read(A_CTRL, r); check("reset_ctrl", r, 32'h1);
        bus_read(A_TX, r);   check("txdata_reads_zero", r, 32'h0);

        // Frame timing at P=4
        bus_write(A_BAUD, 32'd4);
        bus_read(A_BAUD, r); check("baud_rw", r, 32'd4);
        starts.delete();
        send(8'h55, 4, 1'b0);
        e = last_wr;
        repeat (10) @(posedge clk);
        bus_read(A_ST, r); check("busy_mid_frame", r, 32'h05);
        repeat (20) @(posedge clk);
        bus_read(A_ST, r); check("busy_late_frame", r, 32'h05);
        wait_drain(200);
        s0 = (starts.size() > 0) ? starts[0] : -1;
        check("start_latency_p4", 32'(s0), 32'(e + 1));
        bus_read(A_ST, r); check("status_after_frame", r, 32'h01);

        // Minimum divider
        bus_write(A_BAUD, 32'd0);
        starts.delete();
        send(8'hA3, 1, 1'b0);
        e = last_wr;
        wait_drain(60);
        s0 = (starts.size() > 0) ? starts[0] : -1;
        check("start_latency_p1", 32'(s0), 32'(e + 1));

        // Overflow with transmitter disabled, then drain in order
        bus_write(A_BAUD, 32'd2);
        bus_write(A_CTRL, 32'd0);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            if (i < 8) begin
                frame_t f;
                f.data = b; f.p = 2; f.par = 1'b0;
                sb.push_back(f);
            end
            bus_write(A_TX, 32'(b));
        end
        repeat (5) @(posedge clk);
        check("no_tx_while_disabled", 32'(uart_tx), 32'h1);
        bus_read(A_ST, r); check("status_overflow", r, 32'h0A);
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, r); check("overflow_w1c", r, 32'h02);
        starts.delete();
        bus_write(A_CTRL, 32'd1);
        wait_drain(8 * 25 + 50);
        check("drain_frame_count", 32'(starts.size()), 32'd8);
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("frame_gap_%0d", i), 32'(starts[i] - starts[i-1]), 32'd21);
        bus_read(A_ST, r); check("status_after_drain", r, 32'h01);

        // Push into a full FIFO in the same cycle as the pop
        bus_write(A_CTRL, 32'd0);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            begin
                frame_t f;
                f.data = b; f.p = 2; f.par = 1'b0;
                sb.push_back(f);
            end
            bus_write(A_TX, 32'(b));
        end
        bus_write(A_CTRL, 32'd1);
        send(8'($urandom), 2, 1'b0);
        bus_read(A_ST, r); check("full_push_with_pop", r, 32'h06);
        wait_drain(9 * 25 + 50);
        bus_read(A_ST, r); check("status_after_full_pop", r, 32'h01);

        // Randomised dividers, byte counts and write spacing
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(0, 5);
            p = (div == 0) ? 1 : div;
            n = $urandom_range(1, 8);
            bus_write(A_BAUD, 32'(div));
            for (int k = 0; k < n; k++) begin
                send(8'($urandom), p, 1'b0);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            wait_drain(n * (11 * p + 2) + 50);
            bus_read(A_ST, r); check($sformatf("rand_status_%0d", it), r, 32'h01);
        end

        // Reset during data bit 3 (0xC6 bit 3 is 0)
        bus_write(A_BAUD, 32'd4);
        send(8'hC6, 4, 1'b0);
        e = last_wr;
        bus_write(A_TX, 32'h3B);
        while (cyc < e + 18) @(posedge clk);
        #2;
        check("line_in_bit3", 32'(uart_tx), 32'h0);
        rst_n = 1'b0;
        #1;
        check("line_high_on_reset", 32'(uart_tx), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_ST, r);   check("status_after_reset", r, 32'h01);
        bus_read(A_BAUD, r); check("baud_after_reset", r, 32'(DEF_DIV));
        repeat (30) @(posedge clk);
        check("idle_after_reset", 32'(uart_tx), 32'h1);

`ifdef UART_TX_PARITY_EN
        bus_write(A_CTRL, 32'h3);
        bus_read(A_CTRL, r); check("ctrl_parity_rw", r, 32'h3);
        bus_write(A_BAUD, 32'd2);
        send(8'h07, 2, 1'b1);
        wait_drain(100);
`else
        bus_write(A_CTRL, 32'h3);
        bus_read(A_CTRL, r); check("ctrl_bit1_ignored", r, 32'h1);
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
